// File: rtl/ecpri_tx.sv
// eCPRI Remote Memory Access response transmitter: serialises common + RMA header,
// then (read responses only) payload bytes fetched one at a time from local memory.
module ecpri_tx #(
  parameter int          ADDR_W   = 8,
  parameter logic [3:0]  REVISION = 4'h1,
  parameter logic [7:0]  MSG_TYPE = 8'h04
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_send_read_resp,
  input  logic              i_send_write_resp,
  input  logic [7:0]        i_rma_id,
  input  logic [15:0]       i_element_id,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [7:0]        i_tx_payload_len,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic [7:0]        i_mem_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_tx_sop,
  output logic              o_tx_eop,
  output logic              o_busy,
  output logic              o_resp_done,
  output logic              o_req_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_DATA
  } state_t;

  state_t            r_state, w_state_next;
  logic [3:0]        r_idx, w_idx_next;
  logic [7:0]        r_rma_id, w_rma_id_next;
  logic [15:0]       r_elem, w_elem_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [7:0]        r_len, w_len_next;
  logic [7:0]        r_remaining, w_remaining_next;
  logic [7:0]        r_hold, w_hold_next;
  logic              r_is_read, w_is_read_next;

  logic              w_hs;
  logic              w_has_data;
  logic [15:0]       w_pay_size;
  logic [47:0]       w_addr48;
  logic [7:0]        w_hdr_byte;

  assign w_hs       = o_tx_valid & i_tx_ready;
  assign w_has_data = r_is_read & (r_len != 8'd0);
  assign w_pay_size = r_is_read ? (16'd12 + {8'h00, r_len}) : 16'd12;
  assign w_addr48   = 48'(r_addr);

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_idx)
      4'd0:  w_hdr_byte = {REVISION, 4'h0};
      4'd1:  w_hdr_byte = MSG_TYPE;
      4'd2:  w_hdr_byte = w_pay_size[15:8];
      4'd3:  w_hdr_byte = w_pay_size[7:0];
      4'd4:  w_hdr_byte = r_rma_id;
      4'd5:  w_hdr_byte = r_is_read ? 8'h01 : 8'h11;
      4'd6:  w_hdr_byte = r_elem[15:8];
      4'd7:  w_hdr_byte = r_elem[7:0];
      4'd8:  w_hdr_byte = w_addr48[47:40];
      4'd9:  w_hdr_byte = w_addr48[39:32];
      4'd10: w_hdr_byte = w_addr48[31:24];
      4'd11: w_hdr_byte = w_addr48[23:16];
      4'd12: w_hdr_byte = w_addr48[15:8];
      4'd13: w_hdr_byte = w_addr48[7:0];
      4'd14: w_hdr_byte = 8'h00;
      4'd15: w_hdr_byte = r_len;
      default: w_hdr_byte = 8'h00;
    endcase
  end

  // Outputs decode only from registered state, so they hold steady during a stall
  // and collapse to zero the instant the async reset clears the state.
  always_comb begin
    o_tx_valid    = (r_state == S_HDR) || (r_state == S_DATA);
    o_tx_data     = 8'h00;
    if (r_state == S_HDR) begin
      o_tx_data = w_hdr_byte;
    end else if (r_state == S_DATA) begin
      o_tx_data = r_hold;
    end
    o_tx_sop      = (r_state == S_HDR) && (r_idx == 4'd0);
    o_tx_eop      = ((r_state == S_HDR) && (r_idx == 4'd15) && !w_has_data) ||
                    ((r_state == S_DATA) && (r_remaining == 8'd1));
    o_busy        = (r_state != S_IDLE);
    o_resp_done   = w_hs & o_tx_eop;
    o_mem_rd_en   = (r_state == S_RD_REQ);
    o_mem_rd_addr = (r_state == S_RD_REQ) ? r_addr : '0;
    o_req_drop    = !reset && (
                      ((r_state == S_IDLE) && i_send_read_resp && i_send_write_resp) ||
                      ((r_state != S_IDLE) && (i_send_read_resp || i_send_write_resp)));
  end

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_rma_id_next    = r_rma_id;
    w_elem_next      = r_elem;
    w_addr_next      = r_addr;
    w_len_next       = r_len;
    w_remaining_next = r_remaining;
    w_hold_next      = r_hold;
    w_is_read_next   = r_is_read;

    case (r_state)
      S_IDLE: begin
        if (i_send_read_resp || i_send_write_resp) begin
          w_rma_id_next  = i_rma_id;
          w_elem_next    = i_element_id;
          w_addr_next    = i_req_addr;
          w_len_next     = i_tx_payload_len;
          w_is_read_next = i_send_read_resp;
          w_idx_next     = 4'd0;
          w_state_next   = S_HDR;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          if (r_idx == 4'd15) begin
            w_idx_next = 4'd0;
            if (w_has_data) begin
              w_remaining_next = r_len;
              w_state_next     = S_RD_REQ;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end
      end
      S_RD_REQ: begin
        w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_hold_next  = i_mem_rd_data;
        w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_hs) begin
          w_remaining_next = r_remaining - 8'd1;
          w_addr_next      = r_addr + ADDR_W'(1);
          w_state_next     = (r_remaining == 8'd1) ? S_IDLE : S_RD_REQ;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_rma_id    <= 8'h00;
      r_elem      <= 16'h0000;
      r_addr      <= '0;
      r_len       <= 8'h00;
      r_remaining <= 8'h00;
      r_hold      <= 8'h00;
      r_is_read   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_rma_id    <= w_rma_id_next;
      r_elem      <= w_elem_next;
      r_addr      <= w_addr_next;
      r_len       <= w_len_next;
      r_remaining <= w_remaining_next;
      r_hold      <= w_hold_next;
      r_is_read   <= w_is_read_next;
    end
  end

endmodule

// File: tb/tb_ecpri_tx.sv
// Directed bench for ecpri_tx: frames are captured at the falling edge and compared
// byte-by-byte against expected frames built from the request fields.
module tb_ecpri_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_send_read_resp = 1'b0;
  logic        i_send_write_resp = 1'b0;
  logic [7:0]  i_rma_id = 8'h00;
  logic [15:0] i_element_id = 16'h0000;
  logic [7:0]  i_req_addr = 8'h00;
  logic [7:0]  i_tx_payload_len = 8'h00;
  logic        o_mem_rd_en;
  logic [7:0]  o_mem_rd_addr;
  logic [7:0]  i_mem_rd_data = 8'h00;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_tx_sop;
  logic        o_tx_eop;
  logic        o_busy;
  logic        o_resp_done;
  logic        o_req_drop;

  ecpri_tx #(.ADDR_W(8), .REVISION(4'h1), .MSG_TYPE(8'h04)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_send_read_resp  (i_send_read_resp),
    .i_send_write_resp (i_send_write_resp),
    .i_rma_id          (i_rma_id),
    .i_element_id      (i_element_id),
    .i_req_addr        (i_req_addr),
    .i_tx_payload_len  (i_tx_payload_len),
    .o_mem_rd_en       (o_mem_rd_en),
    .o_mem_rd_addr     (o_mem_rd_addr),
    .i_mem_rd_data     (i_mem_rd_data),
    .o_tx_data         (o_tx_data),
    .o_tx_valid        (o_tx_valid),
    .i_tx_ready        (i_tx_ready),
    .o_tx_sop          (o_tx_sop),
    .o_tx_eop          (o_tx_eop),
    .o_busy            (o_busy),
    .o_resp_done       (o_resp_done),
    .o_req_drop        (o_req_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: byte at address a is a + 0x80 (so 0x20..0x22 hold A0 A1 A2).
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h80);
  end
  always @(posedge clk) begin
    if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_rd_addr];
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: accepted bytes {sop,eop,data}, read addresses, pulse counts, stall stability.
  logic [9:0] rx_q[$];
  logic [7:0] rd_q[$];
  int         done_cnt = 0;
  int         drop_cnt = 0;
  int         stall_cnt = 0;
  int         stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word = 10'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        stall_cnt++;
        if (!o_tx_valid || {o_tx_sop, o_tx_eop, o_tx_data} != prev_word) stall_bad++;
      end
      if (o_tx_valid && i_tx_ready) rx_q.push_back({o_tx_sop, o_tx_eop, o_tx_data});
      if (o_mem_rd_en) rd_q.push_back(o_mem_rd_addr);
      if (o_resp_done) done_cnt++;
      if (o_req_drop) drop_cnt++;
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_word  = {o_tx_sop, o_tx_eop, o_tx_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_req(input bit rd, input bit wr, input logic [7:0] rma,
                          input logic [15:0] elem, input logic [7:0] addr, input logic [7:0] len);
    i_rma_id          = rma;
    i_element_id      = elem;
    i_req_addr        = addr;
    i_tx_payload_len  = len;
    i_send_read_resp  = rd;
    i_send_write_resp = wr;
    @(posedge clk);
    #1;
    i_send_read_resp  = 1'b0;
    i_send_write_resp = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int n = 0;
    while (done_cnt == base && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == base) check_val({name, " timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input string name, input int base, input int cnt);
    int n = 0;
    while ((rx_q.size() - base) < cnt && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((rx_q.size() - base) < cnt) check_val({name, " wait_bytes"}, 32'(rx_q.size() - base), 32'(cnt));
  endtask

  task automatic check_frame(input string name, input bit rd, input logic [7:0] rma,
                             input logic [15:0] elem, input logic [7:0] addr, input logic [7:0] len,
                             input int rx_base, input int rd_base, input int done_base);
    logic [7:0]  exp_q[$];
    logic [15:0] ps;
    logic [9:0]  word;
    int          nrd;
    ps = rd ? (16'd12 + {8'h00, len}) : 16'd12;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h04);
    exp_q.push_back(ps[15:8]);
    exp_q.push_back(ps[7:0]);
    exp_q.push_back(rma);
    exp_q.push_back(rd ? 8'h01 : 8'h11);
    exp_q.push_back(elem[15:8]);
    exp_q.push_back(elem[7:0]);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
    exp_q.push_back(addr);
    exp_q.push_back(8'h00);
    exp_q.push_back(len);
    if (rd) for (int k = 0; k < int'(len); k++) exp_q.push_back(8'(addr + 8'(k) + 8'h80));
    check_val({name, " nbytes"}, 32'(rx_q.size() - rx_base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      word = (rx_base + k < rx_q.size()) ? rx_q[rx_base + k] : 10'h3FF;
      check_val($sformatf("%s b%0d sop/eop/data", name, k), 32'(word),
                32'({(k == 0), (k == exp_q.size() - 1), exp_q[k]}));
    end
    nrd = rd ? int'(len) : 0;
    check_val({name, " nreads"}, 32'(rd_q.size() - rd_base), 32'(nrd));
    for (int k = 0; k < nrd && (rd_base + k) < rd_q.size(); k++)
      check_val($sformatf("%s rd_addr%0d", name, k), 32'(rd_q[rd_base + k]), 32'(8'(addr + 8'(k))));
    check_val({name, " resp_done"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  task automatic run_frame(input string name, input bit rd, input logic [7:0] rma,
                           input logic [15:0] elem, input logic [7:0] addr, input logic [7:0] len);
    int rb, db, dn;
    rb = rx_q.size();
    db = rd_q.size();
    dn = done_cnt;
    send_req(rd, !rd, rma, elem, addr, len);
    wait_done(name, dn);
    check_frame(name, rd, rma, elem, addr, len, rb, db, dn);
  endtask

  initial begin
    int rb, db, dn, dr, sc;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset outputs", {o_tx_valid, o_tx_sop, o_tx_eop, o_busy, o_resp_done,
              o_req_drop, o_mem_rd_en, o_tx_data, o_mem_rd_addr}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write response; also check the first cycle after acceptance.
    rb = rx_q.size(); db = rd_q.size(); dn = done_cnt;
    send_req(1'b0, 1'b1, 8'h5A, 16'h0102, 8'h13, 8'd4);
    check_val("accept busy/valid/sop/data", {o_busy, o_tx_valid, o_tx_sop, o_tx_data}, {3'b111, 8'h10});
    wait_done("write", dn);
    check_frame("write", 1'b0, 8'h5A, 16'h0102, 8'h13, 8'd4, rb, db, dn);

    run_frame("read3", 1'b1, 8'h21, 16'hA5C3, 8'h20, 8'd3);

    rand_ready = 1'b1;
    sc = stall_cnt;
    run_frame("read3 stall", 1'b1, 8'h21, 16'hA5C3, 8'h20, 8'd3);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    check_val("stall_hold violations", 32'(stall_bad), 32'd0);
    check_val("stalls exercised", 32'(stall_cnt > sc), 32'd1);

    run_frame("read len0", 1'b1, 8'h09, 16'h1234, 8'h40, 8'd0);
    run_frame("read wrap", 1'b1, 8'h0A, 16'h4321, 8'hFE, 8'd3);

    // Both pulses together: read wins, write dropped.
    rb = rx_q.size(); db = rd_q.size(); dn = done_cnt; dr = drop_cnt;
    send_req(1'b1, 1'b1, 8'h77, 16'hBEEF, 8'h30, 8'd2);
    check_val("both drop", 32'(drop_cnt - dr), 32'd1);
    wait_done("both", dn);
    check_frame("both", 1'b1, 8'h77, 16'hBEEF, 8'h30, 8'd2, rb, db, dn);

    // Write pulse while b6 is presented: dropped, frame untouched.
    rb = rx_q.size(); db = rd_q.size(); dn = done_cnt;
    send_req(1'b1, 1'b0, 8'h66, 16'hCAFE, 8'h50, 8'd2);
    wait_bytes("busy req", rb, 6);
    dr = drop_cnt;
    i_rma_id = 8'hEE; i_element_id = 16'hDEAD; i_req_addr = 8'h99; i_tx_payload_len = 8'd7;
    i_send_write_resp = 1'b1;
    @(posedge clk);
    #1;
    i_send_write_resp = 1'b0;
    check_val("busy drop", 32'(drop_cnt - dr), 32'd1);
    wait_done("busy req", dn);
    check_frame("busy req", 1'b1, 8'h66, 16'hCAFE, 8'h50, 8'd2, rb, db, dn);

    // Reset while b7 is presented.
    rb = rx_q.size(); dn = done_cnt;
    send_req(1'b0, 1'b1, 8'h44, 16'h5566, 8'h70, 8'd1);
    wait_bytes("mid reset", rb, 7);
    reset = 1'b1;
    i_send_write_resp = 1'b1;
    #1;
    check_val("mid reset outputs", {o_tx_valid, o_tx_sop, o_tx_eop, o_busy, o_resp_done,
              o_req_drop, o_mem_rd_en, o_tx_data, o_mem_rd_addr}, 32'h0);
    @(posedge clk);
    #1;
    i_send_write_resp = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("after reset idle", {o_busy, o_tx_valid}, 32'h0);
    check_val("truncated no done", 32'(done_cnt - dn), 32'd0);
    run_frame("post reset", 1'b0, 8'h33, 16'h0BAD, 8'h01, 8'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecpri_tx.md
Name: ecpri_tx

Overview:
eCPRI Remote Memory Access response transmitter, the transmit-side counterpart of the eCPRI receiver.
- On a read- or write-response request it serialises the 4-byte eCPRI common header and the 12-byte memory-access header onto a byte stream.
- For read responses, the header is followed by payload bytes fetched from local memory.
- Output is a valid/ready byte interface with sop/eop, feeding the UDP/IP/Ethernet framer.

Parameters:
ADDR_W, 8, width of local memory address; zero-extended into the 48-bit eCPRI address field
REVISION, 4'h1, eCPRI protocol revision placed in byte 0 [7:4]
MSG_TYPE, 8'h04, eCPRI message type (Remote Memory Access)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
send_read_resp  input  1  one-cycle pulse: start read response
send_write_resp  input  1  one-cycle pulse: start write response
rma_id  input  8  Remote Memory Access ID, echoed from request
element_id  input  16  element ID, echoed from request
req_addr  input  ADDR_W  start address of access
tx_payload_len  input  8  access length in bytes
mem_rd_en  output  1  memory read strobe
mem_rd_addr  output  ADDR_W  memory read address
mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en
tx_data  output  8  stream byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts byte when tx_valid&tx_ready
tx_sop  output  1  first byte of frame
tx_eop  output  1  last byte of frame
busy  output  1  frame in progress
resp_done  output  1  one-cycle pulse on final byte handshake
req_drop  output  1  one-cycle pulse when a request is discarded

Behaviour:
- Reset (async): all outputs 0, state IDLE, counters 0; a frame in flight is truncated with no eop. Request inputs are ignored while reset is high.
- Accept: in IDLE, the first clock edge with send_read_resp|send_write_resp latches rma_id, element_id, req_addr, tx_payload_len and the type. Next cycle: busy=1, state HDR, tx_valid=1.
- If both request pulses are set in the same cycle, read wins, the write is discarded and req_drop pulses.
- Any request while busy=1 is discarded with req_drop.
- Frame bytes, index 0..15:
  - b0={REVISION,4'h0}; b1=MSG_TYPE
  - b2..b3=payload size, big-endian 16-bit = 12 + len (read) or 12 (write)
  - b4=rma_id; b5=8'h01 (read resp) or 8'h11 (write resp)
  - b6..b7=element_id, big-endian
  - b8..b13=48-bit address, big-endian, upper bits zero
  - b14..b15={8'h00,len}
- Read responses append len data bytes. Write responses carry no data.
- tx_sop=1 only while b0 is presented. tx_eop=1 only while the last byte is presented: b15 for a write response or a read with len=0, otherwise the last data byte.
- Handshake: byte index advances only on tx_valid&tx_ready. While tx_valid=1 and tx_ready=0, tx_data, tx_sop and tx_eop are held stable. tx_valid never drops mid-header.
- States: IDLE -> HDR. HDR after b15 accepted -> RD_REQ (read, len>0) or IDLE.
  - RD_REQ: mem_rd_en=1 for one cycle, mem_rd_addr = current address; tx_valid=0.
  - RD_WAIT: capture mem_rd_data into holding register; tx_valid=0.
  - DATA: tx_valid=1 with the held byte. On handshake, decrement the remaining count and increment the address; go to RD_REQ if remaining>0, else IDLE.
- Data throughput: one byte per 3 cycles at minimum. The address increments modulo 2^ADDR_W (wraps 0xFF->0x00 for ADDR_W=8).
- mem_rd_en is never asserted for write responses or when len=0.
- resp_done pulses in the cycle of the final handshake. busy=0 and IDLE follow the next cycle, so a new request is acceptable one cycle after resp_done.
- Payload-size arithmetic is 16-bit, maximum 12+255=267 (0x010B); no overflow.

Test Plan:
1. Write resp, rma_id=0x5A, element_id=0x0102, req_addr=0x13, len=4, tx_ready=1 -> 16 bytes 10 04 00 0C 5A 11 01 02 00 00 00 00 00 13 00 04. sop on b0, eop+resp_done on b15, mem_rd_en never 1.
2. Read resp, addr=0x20, len=3, memory 0x20..0x22=A0 A1 A2 -> header with payload size 00 0F and b5=01, then A0 A1 A2. mem_rd_addr 20,21,22; eop on A2.
3. Test 2 repeated with tx_ready pseudo-random (~50% low) -> identical byte sequence; tx_data/sop/eop stable across every stalled cycle.
4. Read, len=0 -> exactly 16 bytes, payload size 00 0C, eop on b15, no mem_rd_en. Read addr=0xFE, len=3 -> mem_rd_addr FE,FF,00.
5. Both request pulses in one cycle -> single read response, req_drop=1 that cycle. Write pulse at b6 of an active frame -> ignored, req_drop=1, frame unaffected.
6. Reset asserted while b7 is presented -> all outputs 0 immediately. After release, a write request produces a clean full frame starting with sop on 0x10.
